// File: rtl/shape_ctrl_initiator_if.sv
// ----------------------------------------------------------------------------
// shape_ctrl_initiator_if
//   Groups the request, control-register and response signals of the shape
//   control initiator.
//
//   Request  : req_valid, req_ready, req_shape[1:0], req_operation[4:0]
//   Register : write, write_data[31:0], read, read_data[31:0]
//   Response : rsp_valid, rsp_ready, rsp_status[1:0]
//   Status   : busy
//
//   master : the initiator itself (drives req_ready, strobes, response, busy)
//   slave  : its environment (drives the request, read_data and rsp_ready)
// ----------------------------------------------------------------------------
interface shape_ctrl_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_shape;
    logic [4:0]  req_operation;
    logic        write;
    logic [31:0] write_data;
    logic        read;
    logic [31:0] read_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_status;
    logic        busy;

    modport master (
        input  req_valid, req_shape, req_operation, read_data, rsp_ready,
        output req_ready, write, write_data, read, rsp_valid, rsp_status, busy
    );

    modport slave (
        output req_valid, req_shape, req_operation, read_data, rsp_ready,
        input  req_ready, write, write_data, read, rsp_valid, rsp_status, busy
    );
endinterface

// File: rtl/shape_ctrl_initiator.sv
// ----------------------------------------------------------------------------
// shape_ctrl_initiator
//   Accepts a (shape, operation) request, checks its legality, writes it to a
//   control register and reports the outcome on a valid/ready response.
//   With read-back enabled the register is read after each write and compared
//   against the request; mismatches are retried up to MAX_RETRIES times.
//
//   Parameters : MAX_RETRIES (0..7) re-writes after a read-back mismatch
//   Macro      : SHAPE_CTRL_READBACK_EN enables read-back, retry and MISMATCH.
//                When undefined the block goes WRITE -> RESP, read stays low
//                and read_data is ignored.
//   Ports      : clk   - clock, rising edge
//                rst_n - asynchronous, active-low reset
//                bus   - shape_ctrl_initiator_if.master (request, register
//                        write/read, response, busy)
//   Status     : 00 OK, 01 ILLEGAL, 10 MISMATCH
// ----------------------------------------------------------------------------
module shape_ctrl_initiator #(
    parameter int MAX_RETRIES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    shape_ctrl_initiator_if.master        bus
);

    typedef enum logic [2:0] {IDLE, WRITE, READ, SAMPLE, RESP} state_e;

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_ILLEGAL  = 2'b01;
    localparam logic [1:0] ST_MISMATCH = 2'b10;

    state_e     state_q, state_d;
    logic [1:0] shape_q, shape_d;
    logic [4:0] op_q, op_d;
    logic [1:0] status_q, status_d;
    logic       accept;

`ifdef SHAPE_CTRL_READBACK_EN
    localparam logic [2:0] MAX_R = 3'(MAX_RETRIES);
    logic [2:0] retry_q, retry_d;
    logic       match;
`else
    logic       unused_read_data;
`endif

    function automatic logic shape_legal(input logic [1:0] s);
        return (s == 2'b01) || (s == 2'b10);
    endfunction

    function automatic logic op_legal(input logic [4:0] op);
        logic ok;
        case (op[4:3])
            2'b00:   ok = (op[2:0] <= 3'd1);
            2'b01:   ok = (op[2:0] == 3'd0);
            2'b10:   ok = (op[2:0] <= 3'd1);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Class-00 operations pair with any shape; other classes must name the shape.
    function automatic logic req_legal(input logic [1:0] s, input logic [4:0] op);
        return shape_legal(s) && op_legal(op) && ((op[4:3] == 2'b00) || (op[4:3] == s));
    endfunction

    // req_ready is gated by rst_n so it reads low while reset is held.
    assign bus.req_ready  = rst_n && (state_q == IDLE);
    assign accept         = bus.req_valid && bus.req_ready;
    assign bus.write      = (state_q == WRITE);
    assign bus.write_data = (state_q == WRITE) ? {14'd0, shape_q, 11'd0, op_q} : 32'd0;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_status = (state_q == RESP) ? status_q : 2'b00;
    assign bus.busy       = (state_q != IDLE);

`ifdef SHAPE_CTRL_READBACK_EN
    assign bus.read = (state_q == READ);
    // read_data is valid in SAMPLE, the cycle after the read strobe.
    assign match    = (bus.read_data[17:16] == shape_q) && (bus.read_data[4:0] == op_q);
`else
    assign bus.read         = 1'b0;
    assign unused_read_data = ^bus.read_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shape_q  <= 2'b00;
            op_q     <= 5'b00000;
            status_q <= ST_OK;
`ifdef SHAPE_CTRL_READBACK_EN
            retry_q  <= 3'd0;
`endif
        end else begin
            state_q  <= state_d;
            shape_q  <= shape_d;
            op_q     <= op_d;
            status_q <= status_d;
`ifdef SHAPE_CTRL_READBACK_EN
            retry_q  <= retry_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        shape_d  = shape_q;
        op_d     = op_q;
        status_d = status_q;
`ifdef SHAPE_CTRL_READBACK_EN
        retry_d  = retry_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shape_d = bus.req_shape;
                    op_d    = bus.req_operation;
                    if (req_legal(bus.req_shape, bus.req_operation)) begin
                        state_d = WRITE;
`ifdef SHAPE_CTRL_READBACK_EN
                        retry_d = 3'd0;
`endif
                    end else begin
                        state_d  = RESP;
                        status_d = ST_ILLEGAL;
                    end
                end
            end
            WRITE: begin
`ifdef SHAPE_CTRL_READBACK_EN
                state_d = READ;
`else
                state_d  = RESP;
                status_d = ST_OK;
`endif
            end
`ifdef SHAPE_CTRL_READBACK_EN
            READ: state_d = SAMPLE;
            SAMPLE: begin
                if (match) begin
                    state_d  = RESP;
                    status_d = ST_OK;
                end else if (retry_q < MAX_R) begin
                    retry_d = retry_q + 3'd1;
                    state_d = WRITE;
                end else begin
                    state_d  = RESP;
                    status_d = ST_MISMATCH;
                end
            end
`endif
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_shape_ctrl_initiator.sv
// ----------------------------------------------------------------------------
// tb_shape_ctrl_initiator
//   Directed bench for shape_ctrl_initiator (MAX_RETRIES = 2). Inputs change on
//   the falling edge; outputs are checked on the falling edge as one packed
//   vector {req_ready, write, write_data, read, rsp_valid, rsp_status, busy}.
//   Follows SHAPE_CTRL_READBACK_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_shape_ctrl_initiator;

    localparam logic       H   = 1'b1;
    localparam logic       L   = 1'b0;
    localparam logic [31:0] Z32 = 32'h0;
    localparam logic [1:0] OK  = 2'b00;
    localparam logic [1:0] ILL = 2'b01;
    localparam logic [1:0] MIS = 2'b10;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    int   rd_total;

    shape_ctrl_initiator_if bus();

    shape_ctrl_initiator #(.MAX_RETRIES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.read === 1'b1) rd_total++;

    function automatic logic [38:0] obs();
        return {bus.req_ready, bus.write, bus.write_data, bus.read,
                bus.rsp_valid, bus.rsp_status, bus.busy};
    endfunction

    function automatic logic [38:0] ev(input logic rdy, input logic wr, input logic [31:0] wd,
                                       input logic rd, input logic rv, input logic [1:0] st,
                                       input logic bsy);
        return {rdy, wr, wd, rd, rv, st, bsy};
    endfunction

    task automatic test_reset();
        logic [38:0] o;
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_shape = 2'b00; bus.req_operation = 5'd0;
        bus.read_data = 32'd0; bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        o = obs();
        n_cmp++;
        if (o !== ev(L, L, Z32, L, L, OK, L)) begin
            n_bad++; $display("FAIL reset_held: got %h expected %h", o, ev(L, L, Z32, L, L, OK, L));
        end
        rst_n = 1'b1;
        #1;
        o = obs();
        n_cmp++;
        if (o !== ev(H, L, Z32, L, L, OK, L)) begin
            n_bad++; $display("FAIL reset_release: got %h expected %h", o, ev(H, L, Z32, L, L, OK, L));
        end
        @(negedge clk);
    endtask

    task automatic test_legal();
        logic [38:0] o;
        logic [38:0] exp_seq[$];
        bus.req_valid = 1'b1; bus.req_shape = 2'b01; bus.req_operation = 5'b00001;
        bus.read_data = 32'h0001_0001;
        exp_seq.push_back(ev(L, H, 32'h0001_0001, L, L, OK, H));
`ifdef SHAPE_CTRL_READBACK_EN
        exp_seq.push_back(ev(L, L, Z32, H, L, OK, H));
        exp_seq.push_back(ev(L, L, Z32, L, L, OK, H));
`endif
        exp_seq.push_back(ev(L, L, Z32, L, H, OK, H));
        for (int i = 0; i < exp_seq.size(); i++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            o = obs();
            n_cmp++;
            if (o !== exp_seq[i]) begin
                n_bad++; $display("FAIL legal cycle N+%0d: got %h expected %h", i + 1, o, exp_seq[i]);
            end
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        o = obs();
        n_cmp++;
        if (o !== ev(H, L, Z32, L, L, OK, L)) begin
            n_bad++; $display("FAIL legal_idle: got %h expected %h", o, ev(H, L, Z32, L, L, OK, L));
        end
    endtask

    // Shape 10 with an op of class 01 is an illegal pairing, hence the third entry.
    task automatic test_illegal();
        logic [38:0] o;
        logic [1:0]  shp[4] = '{2'b11, 2'b01, 2'b10, 2'b01};
        logic [4:0]  opc[4] = '{5'b00000, 5'b10000, 5'b01000, 5'b00010};
        for (int k = 0; k < 4; k++) begin
            bus.req_valid = 1'b1; bus.req_shape = shp[k]; bus.req_operation = opc[k];
            @(negedge clk);
            bus.req_valid = 1'b0;
            o = obs();
            n_cmp++;
            if (o !== ev(L, L, Z32, L, H, ILL, H)) begin
                n_bad++; $display("FAIL illegal_%0d rsp: got %h expected %h", k, o, ev(L, L, Z32, L, H, ILL, H));
            end
            bus.rsp_ready = 1'b1;
            @(negedge clk);
            bus.rsp_ready = 1'b0;
            o = obs();
            n_cmp++;
            if (o !== ev(H, L, Z32, L, L, OK, L)) begin
                n_bad++; $display("FAIL illegal_%0d idle: got %h expected %h", k, o, ev(H, L, Z32, L, L, OK, L));
            end
        end
    endtask

    // read_data carries stray bits outside the compared fields.
    task automatic test_legal_class10();
        logic [38:0] o;
        logic [38:0] exp_seq[$];
        bus.req_valid = 1'b1; bus.req_shape = 2'b10; bus.req_operation = 5'b10001;
        bus.read_data = 32'hFFFE_FFF1;
        exp_seq.push_back(ev(L, H, 32'h0002_0011, L, L, OK, H));
`ifdef SHAPE_CTRL_READBACK_EN
        exp_seq.push_back(ev(L, L, Z32, H, L, OK, H));
        exp_seq.push_back(ev(L, L, Z32, L, L, OK, H));
`endif
        exp_seq.push_back(ev(L, L, Z32, L, H, OK, H));
        for (int i = 0; i < exp_seq.size(); i++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            o = obs();
            n_cmp++;
            if (o !== exp_seq[i]) begin
                n_bad++; $display("FAIL class10 cycle N+%0d: got %h expected %h", i + 1, o, exp_seq[i]);
            end
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.read_data = 32'd0;
    endtask

`ifdef SHAPE_CTRL_READBACK_EN
    // Register always reads back op 00000, so every compare fails.
    task automatic test_retry();
        logic [38:0] o;
        logic [38:0] exp_seq[$];
        int wr_seen = 0;
        int rd_seen = 0;
        bus.req_valid = 1'b1; bus.req_shape = 2'b01; bus.req_operation = 5'b01000;
        bus.read_data = 32'h0001_0000;
        for (int r = 0; r < 3; r++) begin
            exp_seq.push_back(ev(L, H, 32'h0001_0008, L, L, OK, H));
            exp_seq.push_back(ev(L, L, Z32, H, L, OK, H));
            exp_seq.push_back(ev(L, L, Z32, L, L, OK, H));
        end
        exp_seq.push_back(ev(L, L, Z32, L, H, MIS, H));
        for (int i = 0; i < exp_seq.size(); i++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            o = obs();
            if (bus.write === 1'b1) wr_seen++;
            if (bus.read === 1'b1) rd_seen++;
            n_cmp++;
            if (o !== exp_seq[i]) begin
                n_bad++; $display("FAIL retry cycle N+%0d: got %h expected %h", i + 1, o, exp_seq[i]);
            end
        end
        n_cmp++;
        if (wr_seen !== 3 || rd_seen !== 3) begin
            n_bad++; $display("FAIL retry_counts: got writes=%0d reads=%0d expected 3/3", wr_seen, rd_seen);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.read_data = 32'd0;
    endtask
`endif

    task automatic test_backpressure();
        logic [38:0] o;
        bus.req_valid = 1'b1; bus.req_shape = 2'b00; bus.req_operation = 5'd0;
        @(negedge clk);
        // A legal request is offered the whole time the response is stalled.
        bus.req_shape = 2'b01; bus.req_operation = 5'b00000;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            o = obs();
            n_cmp++;
            if (o !== ev(L, L, Z32, L, H, ILL, H)) begin
                n_bad++; $display("FAIL stall cycle %0d: got %h expected %h", i, o, ev(L, L, Z32, L, H, ILL, H));
            end
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        o = obs();
        n_cmp++;
        if (o !== ev(H, L, Z32, L, L, OK, L)) begin
            n_bad++; $display("FAIL stall_release: got %h expected %h", o, ev(H, L, Z32, L, L, OK, L));
        end
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [38:0] o;
        logic [38:0] strobe_v;
        int          steps;
        bus.req_valid = 1'b1; bus.req_shape = 2'b01; bus.req_operation = 5'b00001;
        bus.read_data = 32'h0001_0001;
`ifdef SHAPE_CTRL_READBACK_EN
        steps    = 2;
        strobe_v = ev(L, L, Z32, H, L, OK, H);
`else
        steps    = 1;
        strobe_v = ev(L, H, 32'h0001_0001, L, L, OK, H);
`endif
        repeat (steps) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
        end
        o = obs();
        n_cmp++;
        if (o !== strobe_v) begin
            n_bad++; $display("FAIL abort_strobe: got %h expected %h", o, strobe_v);
        end
        #1;
        rst_n = 1'b0;
        #1;
        o = obs();
        n_cmp++;
        if (o !== ev(L, L, Z32, L, L, OK, L)) begin
            n_bad++; $display("FAIL abort_immediate: got %h expected %h", o, ev(L, L, Z32, L, L, OK, L));
        end
        @(negedge clk);
        o = obs();
        n_cmp++;
        if (o !== ev(L, L, Z32, L, L, OK, L)) begin
            n_bad++; $display("FAIL abort_next: got %h expected %h", o, ev(L, L, Z32, L, L, OK, L));
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            o = obs();
            n_cmp++;
            if (o !== ev(H, L, Z32, L, L, OK, L)) begin
                n_bad++; $display("FAIL abort_quiet %0d: got %h expected %h", i, o, ev(H, L, Z32, L, L, OK, L));
            end
        end
    endtask

    task automatic test_read_count();
        int exp_rd;
`ifdef SHAPE_CTRL_READBACK_EN
        exp_rd = 6;
`else
        exp_rd = 0;
`endif
        n_cmp++;
        if (rd_total !== exp_rd) begin
            n_bad++; $display("FAIL read_total: got %0d expected %0d", rd_total, exp_rd);
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rd_total = 0;
        test_reset();
        test_legal();
        test_illegal();
        test_legal_class10();
`ifdef SHAPE_CTRL_READBACK_EN
        test_retry();
`endif
        test_backpressure();
        test_reset_mid();
        test_read_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
